// File: rtl/collision_pkg.sv
// Shared constants, platform kinds and the per-lane hit record for the collision scanner.
package collision_pkg;

    localparam int NUM_PLATFORMS   = 90;
    localparam int LANES           = 4;
    localparam int EARTH           = 740;
    localparam int DOODLE_HEIGHT   = 80;
    localparam int DOODLE_WIDTH    = 80;
    localparam int PLATFORM_HEIGHT = 20;
    localparam int PLATFORM_WIDTH  = 120;
    localparam int X_MARGIN        = 39;
    localparam int SCROLL_LINE     = 400;

    function automatic int beats(input int n, input int l);
        return (n + l - 1) / l;
    endfunction

    localparam int BEATS  = beats(NUM_PLATFORMS, LANES);
    localparam int IDX_W  = $clog2(NUM_PLATFORMS);
    localparam int BEAT_W = $clog2(BEATS);

    typedef enum logic [1:0] {
        PK_NORMAL    = 2'd0,
        PK_SPRING    = 2'd1,
        PK_BREAKABLE = 2'd2,
        PK_RESERVED  = 2'd3
    } platform_kind_e;

    typedef struct packed {
        logic               hit;
        logic [IDX_W-1:0]   idx;
        logic signed [10:0] y;
        logic signed [10:0] x;
        platform_kind_e     kind;
    } hit_t;

endpackage

// File: rtl/collision_scanner_if.sv
// Scan request, platform table and result bus between generator/physics and the scanner.
interface collision_scanner_if;
    import collision_pkg::*;

    logic                     start;
    logic [1:0][10:0]         platforms [NUM_PLATFORMS];
    logic [NUM_PLATFORMS-1:0] platform_activation;
    platform_kind_e           platform_kind [NUM_PLATFORMS];
    logic [10:0]              doodle_x;
    logic [9:0]               doodle_y;
    logic                     doodle_fall_direction;
    logic                     busy;
    logic                     result_valid;
    logic                     doodle_collision;
    logic                     move_collision;
    logic                     spring_collision;
    logic                     break_valid;
    logic [IDX_W-1:0]         hit_idx;
    logic [1:0][9:0]          ground;

    modport master (
        output start, platforms, platform_activation, platform_kind,
               doodle_x, doodle_y, doodle_fall_direction,
        input  busy, result_valid, doodle_collision, move_collision,
               spring_collision, break_valid, hit_idx, ground
    );

    modport slave (
        input  start, platforms, platform_activation, platform_kind,
               doodle_x, doodle_y, doodle_fall_direction,
        output busy, result_valid, doodle_collision, move_collision,
               spring_collision, break_valid, hit_idx, ground
    );

endinterface

// File: rtl/collision_lane_check.sv
// Combinational hitbox test of one platform slot against the snapshotted doodle position.
module collision_lane_check
    import collision_pkg::*;
(
    input  logic               in_range,
    input  logic               active,
    input  logic               fall,
    input  logic [IDX_W-1:0]   idx,
    input  logic signed [10:0] slot_y,
    input  logic signed [10:0] slot_x,
    input  platform_kind_e     kind,
    input  logic signed [12:0] dy,
    input  logic signed [12:0] dx,
    output hit_t               result
);

    localparam logic signed [12:0] DH = 13'(DOODLE_HEIGHT);
    localparam logic signed [12:0] DW = 13'(DOODLE_WIDTH);
    localparam logic signed [12:0] PH = 13'(PLATFORM_HEIGHT);
    localparam logic signed [12:0] PW = 13'(PLATFORM_WIDTH);
    localparam logic signed [12:0] XM = 13'(X_MARGIN);

    logic signed [12:0] y13;
    logic signed [12:0] x13;
    logic               in_y;
    logic               in_x;

    always_comb begin
        y13  = {{2{slot_y[10]}}, slot_y};
        x13  = {{2{slot_x[10]}}, slot_x};
        in_y = (dy >= y13 - DH) && (dy <= y13 + PH - DH);
        in_x = (dx >= x13 - PW + XM) && (dx <= x13 + DW);

        result      = '0;
        result.hit  = in_range && active && fall && in_y && in_x;
        result.idx  = idx;
        result.y    = slot_y;
        result.x    = slot_x;
        result.kind = kind;
    end

endmodule

// File: rtl/collision_scanner.sv
// Time-multiplexed platform collision scan: LANES slots per beat, one registered result per start.
module collision_scanner
    import collision_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    collision_scanner_if.slave  bus
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SCAN    = 2'd1;
    localparam logic [1:0] S_RESOLVE = 2'd2;

    logic [1:0]         state;
    logic [BEAT_W-1:0]  beat;
    logic signed [12:0] dy_q;
    logic signed [12:0] dx_q;
    logic               fall_q;
    hit_t               best_land;
    hit_t               best_brk;
    hit_t               land_next;
    hit_t               brk_next;
    hit_t               lane_hit [LANES];

    assign bus.busy = (state != S_IDLE);

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] sel;
        logic             in_range;

        assign idx      = IDX_W'(beat * LANES + l);
        assign in_range = (idx < IDX_W'(NUM_PLATFORMS));
        assign sel      = in_range ? idx : '0;

        collision_lane_check u_check (
            .in_range (in_range),
            .active   (bus.platform_activation[sel]),
            .fall     (fall_q),
            .idx      (idx),
            .slot_y   (bus.platforms[sel][0]),
            .slot_x   (bus.platforms[sel][1]),
            .kind     (bus.platform_kind[sel]),
            .dy       (dy_q),
            .dx       (dx_q),
            .result   (lane_hit[l])
        );
    end

    // Lanes are visited in ascending index order, so strict compares keep the lowest index on ties.
    always_comb begin
        land_next = best_land;
        brk_next  = best_brk;
        for (int l = 0; l < LANES; l++) begin
            if (lane_hit[l].hit) begin
                if (lane_hit[l].kind == PK_BREAKABLE) begin
                    if (!brk_next.hit) brk_next = lane_hit[l];
                end else if (!land_next.hit || (lane_hit[l].y < land_next.y)) begin
                    land_next = lane_hit[l];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                <= S_IDLE;
            beat                 <= '0;
            dy_q                 <= '0;
            dx_q                 <= '0;
            fall_q               <= 1'b0;
            best_land            <= '0;
            best_brk             <= '0;
            bus.result_valid     <= 1'b0;
            bus.doodle_collision <= 1'b0;
            bus.move_collision   <= 1'b0;
            bus.spring_collision <= 1'b0;
            bus.break_valid      <= 1'b0;
            bus.hit_idx          <= '0;
            bus.ground[0]        <= 10'(EARTH);
            bus.ground[1]        <= '0;
        end else begin
            bus.result_valid <= 1'b0;
            bus.break_valid  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state     <= S_SCAN;
                        beat      <= '0;
                        dy_q      <= {3'b000, bus.doodle_y};
                        dx_q      <= {{2{bus.doodle_x[10]}}, bus.doodle_x};
                        fall_q    <= bus.doodle_fall_direction;
                        best_land <= '0;
                        best_brk  <= '0;
                    end
                end
                S_SCAN: begin
                    best_land <= land_next;
                    best_brk  <= brk_next;
                    beat      <= beat + 1'b1;
                    if (beat == BEAT_W'(BEATS - 1)) begin
                        state            <= S_RESOLVE;
                        bus.result_valid <= 1'b1;
                        if (land_next.hit) begin
                            bus.doodle_collision <= 1'b1;
                            bus.hit_idx          <= land_next.idx;
                            bus.ground[0]        <= land_next.y[9:0];
                            bus.ground[1]        <= land_next.x[9:0];
                            bus.move_collision   <= (land_next.y[9:0] < 10'(SCROLL_LINE));
                            bus.spring_collision <= (land_next.kind == PK_SPRING);
                        end else if (brk_next.hit) begin
                            bus.doodle_collision <= 1'b0;
                            bus.break_valid      <= 1'b1;
                            bus.hit_idx          <= brk_next.idx;
                            bus.move_collision   <= 1'b0;
                            bus.spring_collision <= 1'b0;
                        end else begin
                            bus.doodle_collision <= (bus.ground[0] == 10'(EARTH)) &&
                                                    (dy_q > 13'(EARTH - DOODLE_HEIGHT));
                            bus.hit_idx          <= '0;
                            bus.move_collision   <= 1'b0;
                            bus.spring_collision <= 1'b0;
                        end
                    end
                end
                S_RESOLVE: state <= S_IDLE;
                default:   state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_collision_scanner.sv
// Directed bench for collision_scanner with a flat, whole-table reference model checked every cycle.
module tb_collision_scanner;
    import collision_pkg::*;

    localparam int N    = 90;
    localparam int LAT  = 24;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    collision_scanner_if bus();

    collision_scanner dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int errors = 0;
    int checks = 0;
    int rv_count = 0;
    logic chk_en = 1'b0;

    // reference model state
    int m_cnt;
    logic m_dc, m_move, m_spring;
    int m_idx, m_gy, m_gx;
    logic p_land, p_brk, p_spring;
    int p_idx, p_y, p_x, p_dy;

    // captured result of the last directed scan
    int r_lat, r_idx, r_gy, r_gx;
    logic r_dc, r_move, r_spring, r_brk;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic model_scan();
        int best_y, px, py, dx, dy;
        logic signed [10:0] t;
        p_land = 0; p_brk = 0; p_idx = 0; p_spring = 0; best_y = 0;
        t  = bus.doodle_x;
        dx = t;
        dy = int'(bus.doodle_y);
        p_dy = dy;
        for (int i = 0; i < N; i++) begin
            if (bus.platform_activation[i] && bus.doodle_fall_direction) begin
                t = bus.platforms[i][0]; py = t;
                t = bus.platforms[i][1]; px = t;
                if (dy >= py - 80 && dy <= py - 60 && dx >= px - 81 && dx <= px + 80) begin
                    if (bus.platform_kind[i] == PK_BREAKABLE) begin
                        if (!p_brk && !p_land) p_idx = i;
                        p_brk = 1;
                    end else if (!p_land || py < best_y) begin
                        p_land = 1; best_y = py; p_idx = i; p_y = py; p_x = px;
                        p_spring = (bus.platform_kind[i] == PK_SPRING);
                    end
                end
            end
        end
    endtask

    task automatic model_apply();
        if (p_land) begin
            m_dc = 1; m_idx = p_idx;
            m_gy = p_y & 1023; m_gx = p_x & 1023;
            m_move = (m_gy < 400); m_spring = p_spring;
        end else if (p_brk) begin
            m_dc = 0; m_idx = p_idx; m_move = 0; m_spring = 0;
        end else begin
            m_dc = (m_gy == 740) && (p_dy > 660);
            m_idx = 0; m_move = 0; m_spring = 0;
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_cnt = 0; m_dc = 0; m_move = 0; m_spring = 0;
            m_idx = 0; m_gy = 740; m_gx = 0; p_brk = 0; p_land = 0;
        end else if (m_cnt == 0) begin
            if (bus.start) begin
                model_scan();
                m_cnt = LAT;
            end
        end else begin
            m_cnt--;
            if (m_cnt == 1) model_apply();
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", int'(bus.busy), int'(m_cnt > 0));
            check("result_valid", int'(bus.result_valid), int'(m_cnt == 1));
            check("doodle_collision", int'(bus.doodle_collision), int'(m_dc));
            check("ground_y", int'(bus.ground[0]), m_gy);
            check("ground_x", int'(bus.ground[1]), m_gx);
            check("break_valid", int'(bus.break_valid), int'(m_cnt == 1 && p_brk && !p_land));
            if (bus.result_valid) begin
                rv_count++;
                check("hit_idx", int'(bus.hit_idx), m_idx);
                check("move_collision", int'(bus.move_collision), int'(m_move));
                check("spring_collision", int'(bus.spring_collision), int'(m_spring));
            end
        end
    end

    task automatic clear_slots();
        for (int i = 0; i < N; i++) begin
            bus.platforms[i][0] = '0;
            bus.platforms[i][1] = '0;
            bus.platform_activation[i] = 1'b0;
            bus.platform_kind[i] = PK_NORMAL;
        end
    endtask

    task automatic set_slot(input int i, input int y, input int x, input platform_kind_e k);
        bus.platforms[i][0] = 11'(y);
        bus.platforms[i][1] = 11'(x);
        bus.platform_activation[i] = 1'b1;
        bus.platform_kind[i] = k;
    endtask

    task automatic run_scan(input int dy, input int dx, input logic fall, input int poke);
        bus.doodle_y = 10'(dy);
        bus.doodle_x = 11'(dx);
        bus.doodle_fall_direction = fall;
        bus.start = 1'b1;
        r_lat = 0;
        while (r_lat <= 40) begin
            @(negedge clk);
            r_lat++;
            bus.start = (poke != 0 && r_lat == poke);
            if (bus.result_valid) break;
        end
        bus.start = 1'b0;
        r_dc = bus.doodle_collision; r_idx = int'(bus.hit_idx);
        r_move = bus.move_collision; r_spring = bus.spring_collision;
        r_brk = bus.break_valid;
        r_gy = int'(bus.ground[0]); r_gx = int'(bus.ground[1]);
        @(negedge clk);
    endtask

    typedef struct { int dy; int dx; int hit; } bnd_t;
    bnd_t bnd [8] = '{'{420,300,1}, '{419,300,0}, '{440,300,1}, '{441,300,0},
                      '{425,219,1}, '{425,218,0}, '{425,380,1}, '{425,381,0}};

    int rv_before;

    initial begin
        rst = 1'b1;
        bus.start = 1'b1;
        bus.doodle_x = '0; bus.doodle_y = '0; bus.doodle_fall_direction = 1'b1;
        clear_slots();
        @(negedge clk);
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        bus.start = 1'b0;
        rst = 1'b0;
        check("rst_ground_y", int'(bus.ground[0]), 740);
        check("rst_ground_x", int'(bus.ground[1]), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_rv_count", rv_count, 0);
        @(negedge clk);

        set_slot(5, 500, 300, PK_NORMAL);
        run_scan(425, 300, 1'b1, 0);
        check("t2_latency", r_lat, 24);
        check("t2_dc", int'(r_dc), 1);
        check("t2_gy", r_gy, 500);
        check("t2_gx", r_gx, 300);
        check("t2_idx", r_idx, 5);
        check("t2_move", int'(r_move), 0);

        clear_slots();
        set_slot(7, 300, 200, PK_SPRING);
        set_slot(60, 310, 200, PK_NORMAL);
        run_scan(225, 200, 1'b1, 0);
        check("t3_idx", r_idx, 7);
        check("t3_spring", int'(r_spring), 1);
        check("t3_move", int'(r_move), 1);
        check("t3_gy", r_gy, 300);

        clear_slots();
        set_slot(20, 310, 200, PK_NORMAL);
        set_slot(70, 300, 200, PK_NORMAL);
        run_scan(235, 200, 1'b1, 0);
        check("t3b_idx", r_idx, 70);
        check("t3b_spring", int'(r_spring), 0);

        clear_slots();
        set_slot(10, 500, 300, PK_NORMAL);
        set_slot(11, 500, 300, PK_NORMAL);
        run_scan(425, 300, 1'b1, 0);
        check("t4_tie_idx", r_idx, 10);
        check("t4_tie_gy", r_gy, 500);

        clear_slots();
        set_slot(3, 500, 300, PK_BREAKABLE);
        run_scan(425, 300, 1'b1, 0);
        check("t4_brk_valid", int'(r_brk), 1);
        check("t4_brk_idx", r_idx, 3);
        check("t4_brk_dc", int'(r_dc), 0);
        check("t4_brk_gy", r_gy, 500);

        clear_slots();
        set_slot(5, 500, 300, PK_NORMAL);
        for (int k = 0; k < 8; k++) begin
            run_scan(bnd[k].dy, bnd[k].dx, 1'b1, 0);
            check($sformatf("bnd%0d_dc", k), int'(r_dc), bnd[k].hit);
            check($sformatf("bnd%0d_idx", k), r_idx, bnd[k].hit != 0 ? 5 : 0);
        end

        run_scan(425, 300, 1'b0, 0);
        check("t5_nofall_latency", r_lat, 24);
        check("t5_nofall_dc", int'(r_dc), 0);
        check("t5_nofall_idx", r_idx, 0);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        clear_slots();
        run_scan(660, 0, 1'b1, 0);
        check("t5_earth_edge_dc", int'(r_dc), 0);
        run_scan(700, 0, 1'b1, 0);
        check("t5_earth_dc", int'(r_dc), 1);
        check("t5_earth_gy", r_gy, 740);

        set_slot(5, 500, 300, PK_NORMAL);
        rv_before = rv_count;
        run_scan(425, 300, 1'b1, 5);
        repeat (30) @(negedge clk);
        check("t5_busy_start_results", rv_count - rv_before, 1);
        check("t5_busy_start_latency", r_lat, 24);

        rv_before = rv_count;
        bus.doodle_y = 10'd425; bus.doodle_x = 11'd300; bus.doodle_fall_direction = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_busy_after_rst", int'(bus.busy), 0);
        check("t6_ground_after_rst", int'(bus.ground[0]), 740);
        repeat (30) @(negedge clk);
        check("t6_no_result", rv_count - rv_before, 0);
        run_scan(425, 300, 1'b1, 0);
        check("t6_restart_latency", r_lat, 24);
        check("t6_restart_idx", r_idx, 5);
        check("t6_restart_gy", r_gy, 500);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
